dm_store_buffer: RTL and testbench

- Posted-write buffer directly upstream of the data memory, fed by the MEM stage.
- Accepts committed stores (sw/sh/sb) into an in-order FIFO and drains one store per cycle to the DM write port.
- Answers same-cycle load lookups: forwards full-word matches, or flags a partial match so the hazard unit stalls.
- Carries each store's PC so the DM can print its write-trace line on drain.

---
 rtl/cpu_defs.sv | 18 +
 rtl/dm_sb_match.sv | 37 +++
 rtl/dm_store_buffer.sv | 118 +++++++++++
 tb/tb_dm_store_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared constants and store-entry field widths for the data-memory path
package cpu_defs;

  localparam logic [3:0] BE_WORD  = 4'hF;
  localparam int         SB_DEPTH = 4;
  localparam int         SB_AW    = 32;
  localparam int         SB_DW    = 32;
  localparam int         SB_BEW   = 4;
  localparam int         SB_PCW   = 32;

  typedef struct packed {
    logic [SB_AW-3:0]  waddr;
    logic [SB_DW-1:0]  data;
    logic [SB_BEW-1:0] be;
    logic [SB_PCW-1:0] pc;
  } sb_entry_t;

endpackage

// File: rtl/dm_sb_match.sv
// rtl/dm_sb_match.sv - parallel word-address compare with youngest-match priority over the store buffer
module dm_sb_match
  import cpu_defs::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [AW-3:0] entry_waddr [DEPTH],
  input  logic [3:0]    entry_be    [DEPTH],
  input  logic [AW-3:0] ld_waddr,
  input  logic [PW-1:0] head,
  input  logic [PW:0]   count,
  output logic          hit,
  output logic [PW-1:0] idx,
  output logic          full
);

  localparam int CW = PW + 1;

  // Walk from oldest to youngest so the last match seen wins.
  always_comb begin
    logic [PW-1:0] pos;
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pos = head + PW'(k);
      if ((CW'(k) < count) && (entry_waddr[pos] == ld_waddr)) begin
        hit = 1'b1;
        idx = pos;
      end
    end
    full = hit && (entry_be[idx] == BE_WORD);
  end

endmodule

// File: rtl/dm_store_buffer.sv
// rtl/dm_store_buffer.sv - in-order posted-write buffer in front of the data memory with load forwarding
module dm_store_buffer
  import cpu_defs::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  input  logic [3:0]    st_be,
  input  logic [31:0]   st_pc,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_fwd_valid,
  output logic [DW-1:0] ld_fwd_data,
  output logic          ld_conflict,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  output logic [3:0]    dm_be,
  output logic [31:0]   dm_pc,
  input  logic          dm_ready,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-3:0] q_waddr [DEPTH];
  logic [DW-1:0] q_data  [DEPTH];
  logic [3:0]    q_be    [DEPTH];
  logic [31:0]   q_pc    [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          hit;
  logic          hit_full;
  logic [PW-1:0] hit_idx;
  logic          addr_lsb_unused;

  assign addr_lsb_unused = ^{ld_addr[1:0], st_addr[1:0]};

  assign st_ready = (count != CW'(DEPTH));
  assign empty    = (count == '0);
  assign dm_we    = !empty;
  assign push     = st_valid && st_ready;
  assign pop      = dm_we && dm_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry validity is tracked by head/count, so the payload array needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_waddr[tail] <= st_addr[AW-1:2];
      q_data[tail]  <= st_data;
      q_be[tail]    <= st_be;
      q_pc[tail]    <= st_pc;
    end
  end

  // Head fields are gated so the DM never sees stale payload when idle.
  always_comb begin
    dm_addr  = '0;
    dm_wdata = '0;
    dm_be    = '0;
    dm_pc    = '0;
    if (dm_we) begin
      dm_addr  = {q_waddr[head], 2'b00};
      dm_wdata = q_data[head];
      dm_be    = q_be[head];
      dm_pc    = q_pc[head];
    end
  end

  dm_sb_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .PW    (PW)
  ) u_match (
    .entry_waddr (q_waddr),
    .entry_be    (q_be),
    .ld_waddr    (ld_addr[AW-1:2]),
    .head        (head),
    .count       (count),
    .hit         (hit),
    .idx         (hit_idx),
    .full        (hit_full)
  );

  always_comb begin
    ld_fwd_valid = ld_valid && hit && hit_full;
    ld_conflict  = ld_valid && hit && !hit_full;
    ld_fwd_data  = ld_fwd_valid ? q_data[hit_idx] : '0;
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// tb/tb_dm_store_buffer.sv - directed and randomized check of dm_store_buffer against a queue model
module tb_dm_store_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] pc;
  } st_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [31:0] st_pc;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_fwd_valid;
  logic [31:0] ld_fwd_data;
  logic        ld_conflict;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_pc;
  logic        dm_ready;
  logic        empty;

  int n_assert = 0;
  int n_fail   = 0;
  st_t q[$];

  always #5 clk = ~clk;

  dm_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .st_valid     (st_valid),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_be        (st_be),
    .st_pc        (st_pc),
    .st_ready     (st_ready),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_fwd_valid (ld_fwd_valid),
    .ld_fwd_data  (ld_fwd_data),
    .ld_conflict  (ld_conflict),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_be        (dm_be),
    .dm_pc        (dm_pc),
    .dm_ready     (dm_ready),
    .empty        (empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: the buffer is a plain queue; a load sees the youngest matching store.
  task automatic check_model();
    logic        e_fv, e_cf, found;
    logic [31:0] e_fd;
    e_fv = 1'b0; e_cf = 1'b0; e_fd = '0; found = 1'b0;
    chk("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
    chk("empty",    32'(empty),    32'(q.size() == 0));
    chk("dm_we",    32'(dm_we),    32'(q.size() != 0));
    chk("dm_addr",  dm_addr,  q.size() ? {q[0].addr[31:2], 2'b00} : 32'h0);
    chk("dm_wdata", dm_wdata, q.size() ? q[0].data : 32'h0);
    chk("dm_be",    32'(dm_be), q.size() ? 32'(q[0].be) : 32'h0);
    chk("dm_pc",    dm_pc,    q.size() ? q[0].pc : 32'h0);
    if (ld_valid) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!found && q[i].addr[31:2] == ld_addr[31:2]) begin
          found = 1'b1;
          if (q[i].be == 4'hF) begin e_fv = 1'b1; e_fd = q[i].data; end
          else e_cf = 1'b1;
        end
      end
    end
    chk("ld_fwd_valid", 32'(ld_fwd_valid), 32'(e_fv));
    chk("ld_conflict",  32'(ld_conflict),  32'(e_cf));
    chk("ld_fwd_data",  ld_fwd_data, e_fd);
  endtask

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [3:0] sbe, input logic [31:0] spc,
                       input logic lv, input logic [31:0] la, input logic dr);
    @(negedge clk);
    st_valid = sv; st_addr = sa; st_data = sd; st_be = sbe; st_pc = spc;
    ld_valid = lv; ld_addr = la; dm_ready = dr;
    #1;
    check_model();
  endtask

  task automatic tick();
    st_t e;
    bit  can_push, do_pop;
    @(posedge clk);
    if (!reset) begin
      q.delete();
    end else begin
      can_push = (q.size() < DEPTH);
      do_pop   = (q.size() != 0) && dm_ready;
      if (do_pop) void'(q.pop_front());
      if (st_valid && can_push) begin
        e.addr = st_addr; e.data = st_data; e.be = st_be; e.pc = st_pc;
        q.push_back(e);
      end
    end
  endtask

  initial begin
    logic [31:0] ra, rd;
    logic [3:0]  rbe;
    logic        rsv, rlv;
    reset = 1'b0;
    st_valid = 0; st_addr = 0; st_data = 0; st_be = 0; st_pc = 0;
    ld_valid = 1; ld_addr = 0; dm_ready = 1;
    #1;
    check_model();
    chk("rst_st_ready", 32'(st_ready), 32'h1);
    chk("rst_dm_we", 32'(dm_we), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Latency/trace: stored on one edge, visible to the DM right after it
    drive(1, 32'h100, 32'h55, 4'hF, 32'h3008, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("lat_we", 32'(dm_we), 32'h1);
    chk("lat_addr", dm_addr, 32'h100);
    chk("lat_data", dm_wdata, 32'h55);
    chk("lat_be", 32'(dm_be), 32'hF);
    chk("lat_pc", dm_pc, 32'h3008);
    tick();

    // Fill and stall, then drain while a held store enters after a slot frees
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h10 + 32'(4 * i), 32'hA000 + 32'(i), 4'hF, 32'h2000 + 32'(4 * i), 0, 0, 0);
      tick();
    end
    drive(1, 32'h20, 32'hA004, 4'hF, 32'h2010, 0, 0, 0);
    chk("full_st_ready", 32'(st_ready), 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(i < 2, 32'h20, 32'hA004, 4'hF, 32'h2010, 0, 0, 1);
      chk("drain_order", dm_addr, 32'h10 + 32'(4 * i));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("drained_empty", 32'(empty), 32'h1);

    // Forwarding: youngest full-word store wins
    drive(1, 32'h40, 32'hDEADBEEF, 4'hF, 32'h3000, 0, 0, 0); tick();
    drive(1, 32'h40, 32'h12345678, 4'hF, 32'h3004, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 32'h42, 0);
    chk("fwd_valid", 32'(ld_fwd_valid), 32'h1);
    chk("fwd_data", ld_fwd_data, 32'h12345678);
    tick();

    // Partial overlap stalls until the byte store drains
    drive(1, 32'h80, 32'h0000AB00, 4'b0010, 32'h3010, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 32'h80, 0);
    chk("part_conflict", 32'(ld_conflict), 32'h1);
    chk("part_fwd", 32'(ld_fwd_valid), 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 32'h80, 1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 1, 32'h80, 0);
    chk("part_cleared", 32'(ld_conflict), 32'h0);

    // Asynchronous reset between edges discards pending stores
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h300 + 32'(4 * i), 32'(i), 4'hF, 32'h4000, 0, 0, 0);
      tick();
    end
    @(negedge clk);
    st_valid = 0; dm_ready = 1;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_we", 32'(dm_we), 32'h0);
    chk("arst_empty", 32'(empty), 32'h1);
    chk("arst_st_ready", 32'(st_ready), 32'h1);
    q.delete();
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("arst_no_write", 32'(dm_we), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic over a small address window to force overlaps
    for (int n = 0; n < 400; n++) begin
      rsv = 1'($urandom_range(0, 1));
      rlv = rsv ? 1'b0 : 1'($urandom_range(0, 1));
      ra  = 32'h200 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      rd  = $urandom;
      rbe = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom_range(1, 14));
      drive(rsv, ra, rd, rbe, $urandom, rlv,
            32'h200 + 32'(4 * $urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
